// File: rtl/gated_rx_fifo_pkg.sv
// Shared types and constants for the gated receive FIFO.
package gated_rx_fifo_pkg;

  localparam int DATA_W           = 16;
  localparam int MAX_CH           = 8;
  localparam int CH_IDX_W         = $clog2(MAX_CH);
  localparam int DEF_AW           = 12;
  localparam int DEF_PACKET_WORDS = 256;

  // Frame writer states; PAD is only entered when gate padding is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } wr_state_e;

  // Effective channel count: 0 disables capture, anything above MAX_CH clamps.
  function automatic logic [3:0] eff_nch(input logic [3:0] channels);
    return (channels > 4'(MAX_CH)) ? 4'(MAX_CH) : channels;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, synchronous write, registered synchronous read.
// The read register clears on reset and on the synchronous clr input.
module fifo_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_d, rdata_q;

  // Storage array write port.
  // NOTE: the array has no reset; only the read register does, so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Next read-register value: clear, load on read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (clr)     rdata_d = '0;
    else if (re) rdata_d = mem[raddr];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gated_rx_fifo.sv
// Gated receive FIFO between the DDC sample path and the FX2 read side.
// A qualified strobe captures eight channel samples; the writer then emits
// the first nch of them, one word per clock. Optional build macro
// GATE_PAD_EN zero-pads the final partial packet when the gate closes.
// PACKET_WORDS must be a power of two for the padding counter.
module gated_rx_fifo
  import gated_rx_fifo_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int PACKET_WORDS = DEF_PACKET_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_reset,
  input  logic              strobe,
  input  logic              gate_enable,
  input  logic [3:0]        channels,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic [DATA_W-1:0] din4,
  input  logic [DATA_W-1:0] din5,
  input  logic [DATA_W-1:0] din6,
  input  logic [DATA_W-1:0] din7,
  input  logic              rd_req,
  input  logic              clear_status,
  output logic [DATA_W-1:0] dout,
  output logic              packet_rdy,
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PKT_CNT  = (AW+1)'(PACKET_WORDS);

  logic [DATA_W-1:0]   din_a [MAX_CH];
  logic [DATA_W-1:0]   cap_d [MAX_CH];
  logic [DATA_W-1:0]   cap_q [MAX_CH];
  wr_state_e           state_d, state_q;
  logic [CH_IDX_W-1:0] ch_idx_d, ch_idx_q;
  logic [3:0]          nch_d, nch_q;
  logic [3:0]          nch_in;
  logic [AW-1:0]       wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0]         count_d, count_q;
  logic                packet_rdy_d, packet_rdy_q;
  logic                overflow_d, overflow_q;
  logic                strobe_qual, full;
  logic                wr_req, ovf_set, do_write, do_read;
  logic [DATA_W-1:0]   wr_data;
  logic                pad_go, pad_last;

  assign din_a       = '{din0, din1, din2, din3, din4, din5, din6, din7};
  assign nch_in      = eff_nch(channels);
  assign strobe_qual = strobe & gate_enable;
  assign full        = (count_q == FULL_CNT);

`ifdef GATE_PAD_EN
  localparam int PF_W = $clog2(PACKET_WORDS);

  logic            gate_d1_q, gate_d1_d;
  logic            pad_pending_d, pad_pending_q;
  logic [PF_W-1:0] pkt_fill_d, pkt_fill_q;

  assign pad_go   = pad_pending_q && (pkt_fill_q != '0);
  assign pad_last = &pkt_fill_q;

  // Gate edge tracking, pending-pad request and words-in-packet position.
  always_comb begin
    gate_d1_d     = gate_enable;
    pad_pending_d = (gate_d1_q & ~gate_enable) | (pad_pending_q & (state_q == EMIT));
    pkt_fill_d    = pkt_fill_q + PF_W'(do_write);
    if (bus_reset) begin
      gate_d1_d     = 1'b0;
      pad_pending_d = 1'b0;
      pkt_fill_d    = '0;
    end
  end

  // Padding state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_d1_q     <= 1'b0;
      pad_pending_q <= 1'b0;
      pkt_fill_q    <= '0;
    end else begin
      gate_d1_q     <= gate_d1_d;
      pad_pending_q <= pad_pending_d;
      pkt_fill_q    <= pkt_fill_d;
    end
  end
`else
  assign pad_go   = 1'b0;
  assign pad_last = 1'b1;
`endif

  // Frame writer: capture on a qualified strobe, then emit one word per cycle.
  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    nch_d    = nch_q;
    cap_d    = cap_q;
    wr_req   = 1'b0;
    wr_data  = '0;
    ovf_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pad_go) begin
          state_d = PAD;
          ovf_set = strobe_qual;
        end else if (strobe_qual && (nch_in != 4'd0)) begin
          cap_d    = din_a;
          nch_d    = nch_in;
          ch_idx_d = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        wr_req  = 1'b1;
        wr_data = cap_q[ch_idx_q];
        ovf_set = strobe_qual;
        if ({1'b0, ch_idx_q} == (nch_q - 4'd1)) state_d = IDLE;
        else                                    ch_idx_d = ch_idx_q + 1'b1;
      end
      PAD: begin
        ovf_set = strobe_qual;
        if (full) begin
          state_d = IDLE;
        end else begin
          wr_req = 1'b1;
          if (pad_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Only a data word may flag a full-FIFO drop; padding stops before full.
    if (wr_req && full && (state_q == EMIT)) ovf_set = 1'b1;
    if (bus_reset) begin
      state_d  = IDLE;
      ch_idx_d = '0;
      ovf_set  = 1'b0;
    end
  end

  // Pointers, occupancy and status flags.
  always_comb begin
    do_write     = wr_req && !full && !bus_reset;
    do_read      = rd_req && (count_q != '0) && !bus_reset;
    wr_ptr_d     = wr_ptr_q + AW'(do_write);
    rd_ptr_d     = rd_ptr_q + AW'(do_read);
    count_d      = count_q + (AW+1)'(do_write) - (AW+1)'(do_read);
    overflow_d   = ovf_set ? 1'b1 : (clear_status ? 1'b0 : overflow_q);
    packet_rdy_d = (count_d >= PKT_CNT);
    if (bus_reset) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      packet_rdy_d = 1'b0;
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ch_idx_q     <= '0;
      nch_q        <= '0;
      cap_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      packet_rdy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      nch_q        <= nch_d;
      cap_q        <= cap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      packet_rdy_q <= packet_rdy_d;
    end
  end

  fifo_ram #(
    .AW(AW),
    .DW(DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .clr   (bus_reset),
    .we    (do_write),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (do_read),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign packet_rdy = packet_rdy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gated_rx_fifo.sv
// Directed self-checking bench for gated_rx_fifo (default build, no padding).
module tb_gated_rx_fifo;
  import gated_rx_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_reset = 1'b0;
  logic        strobe = 1'b0;
  logic        gate_enable = 1'b0;
  logic        rd_req = 1'b0;
  logic        clear_status = 1'b0;
  logic [3:0]  channels = 4'd0;
  logic [15:0] din [8];
  logic [15:0] dout;
  logic        packet_rdy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gated_rx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .bus_reset    (bus_reset),
    .strobe       (strobe),
    .gate_enable  (gate_enable),
    .channels     (channels),
    .din0         (din[0]),
    .din1         (din[1]),
    .din2         (din[2]),
    .din3         (din[3]),
    .din4         (din[4]),
    .din5         (din[5]),
    .din6         (din[6]),
    .din7         (din[7]),
    .rd_req       (rd_req),
    .clear_status (clear_status),
    .dout         (dout),
    .packet_rdy   (packet_rdy),
    .overflow     (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic [15:0] base);
    for (int j = 0; j < 8; j++) din[j] = base + 16'(j);
  endtask

  // One complete frame: strobe cycle followed by the effective number of write cycles.
  task automatic frame(input logic [3:0] ch, input logic [15:0] base);
    int n;
    n = (ch > 4'd8) ? 8 : int'(ch);
    channels    = ch;
    set_din(base);
    gate_enable = 1'b1;
    strobe      = 1'b1;
    step();
    strobe      = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", dout); end
    checks++; if (packet_rdy !== 1'b0) begin errors++; $display("FAIL reset_pkt got %b exp 0", packet_rdy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", dut.count_q); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    channels = 4'd2;
    din[0] = 16'h0010;
    din[1] = 16'h0011;
    gate_enable = 1'b1;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", dut.count_q); end
    step();
    checks++; if (dut.count_q !== 13'd1) begin errors++; $display("FAIL single_cnt1 got %0d exp 1", dut.count_q); end
    step();
    checks++; if (dut.count_q !== 13'd2) begin errors++; $display("FAIL single_cnt2 got %0d exp 2", dut.count_q); end
    rd_req = 1'b1;
    step();
    checks++; if (dout !== 16'h0010) begin errors++; $display("FAIL single_rd0 got %h exp 0010", dout); end
    step();
    checks++; if (dout !== 16'h0011) begin errors++; $display("FAIL single_rd1 got %h exp 0011", dout); end
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL single_cnt_end got %0d exp 0", dut.count_q); end
    step();
    checks++; if (dout !== 16'h0011) begin errors++; $display("FAIL empty_read_hold got %h exp 0011", dout); end
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL empty_read_cnt got %0d exp 0", dut.count_q); end
    rd_req = 1'b0;
  endtask

  task automatic test_gate_off();
    gate_enable = 1'b0;
    channels = 4'd2;
    set_din(16'h0055);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (3) step();
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL gate_off_cnt got %0d exp 0", dut.count_q); end
    checks++; if (dout !== 16'h0011) begin errors++; $display("FAIL gate_off_dout got %h exp 0011", dout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL gate_off_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_channel_bounds();
    frame(4'd0, 16'h0077);
    repeat (3) step();
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL ch0_cnt got %0d exp 0", dut.count_q); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ch0_ovf got %b exp 0", overflow); end
    frame(4'd12, 16'h0100);
    checks++; if (dut.count_q !== 13'd8) begin errors++; $display("FAIL ch12_cnt got %0d exp 8", dut.count_q); end
    repeat (3) step();
    checks++; if (dut.count_q !== 13'd8) begin errors++; $display("FAIL ch12_cnt_hold got %0d exp 8", dut.count_q); end
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (dout !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL ch12_data[%0d] got %h exp %h", k, dout, 16'h0100 + 16'(k)); end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    channels = 4'd4;
    set_din(16'h0040);
    gate_enable = 1'b1;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (dut.count_q !== 13'd1) begin errors++; $display("FAIL rw_cnt[%0d] got %0d exp 1", k, dut.count_q); end
      checks++; if (dout !== 16'h0040 + 16'(k)) begin errors++; $display("FAIL rw_data[%0d] got %h exp %h", k, dout, 16'h0040 + 16'(k)); end
    end
    step();
    checks++; if (dout !== 16'h0043) begin errors++; $display("FAIL rw_last got %h exp 0043", dout); end
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL rw_cnt_end got %0d exp 0", dut.count_q); end
    rd_req = 1'b0;
  endtask

  task automatic test_packet();
    logic [15:0] exp_w;
    channels = 4'd2;
    gate_enable = 1'b1;
    for (int i = 0; i < 128; i++) begin
      set_din(16'(8 * i));
      strobe = 1'b1;
      step();
      strobe = 1'b0;
      step();
      if (i == 127) begin
        checks++; if (packet_rdy !== 1'b0) begin errors++; $display("FAIL pkt_at_255 got %b exp 0", packet_rdy); end
      end
      step();
      checks++; if (packet_rdy !== ((2 * (i + 1)) >= 256)) begin errors++; $display("FAIL pkt_frame[%0d] got %b", i, packet_rdy); end
    end
    checks++; if (dut.count_q !== 13'd256) begin errors++; $display("FAIL pkt_cnt got %0d exp 256", dut.count_q); end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    checks++; if (packet_rdy !== 1'b0) begin errors++; $display("FAIL pkt_fall got %b exp 0", packet_rdy); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL pkt_word0 got %h exp 0000", dout); end
    rd_req = 1'b1;
    for (int k = 1; k < 256; k++) begin
      step();
      exp_w = 16'(8 * (k / 2) + (k % 2));
      checks++; if (dout !== exp_w) begin errors++; $display("FAIL pkt_word[%0d] got %h exp %h", k, dout, exp_w); end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_overflow();
    for (int f = 0; f < 512; f++) frame(4'd8, 16'(f * 8));
    checks++; if (dut.count_q !== 13'd4096) begin errors++; $display("FAIL full_cnt got %0d exp 4096", dut.count_q); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_pre got %b exp 0", overflow); end
    checks++; if (packet_rdy !== 1'b1) begin errors++; $display("FAIL full_pkt got %b exp 1", packet_rdy); end
    channels = 4'd8;
    set_din(16'h0F00);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (7) step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_set got %b exp 1", overflow); end
    checks++; if (dut.count_q !== 13'd4096) begin errors++; $display("FAIL full_cnt_hold got %0d exp 4096", dut.count_q); end
    clear_status = 1'b1;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b exp 1", overflow); end
    step();
    clear_status = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (dout !== 16'(k)) begin errors++; $display("FAIL full_head[%0d] got %h exp %h", k, dout, 16'(k)); end
    end
    rd_req = 1'b0;
    frame(4'd8, 16'h00A0);
    checks++; if (dut.count_q !== 13'd4096) begin errors++; $display("FAIL refill_cnt got %0d exp 4096", dut.count_q); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL refill_ovf got %b exp 1", overflow); end
    rd_req = 1'b1;
    for (int k = 3; k < 4096; k++) begin
      step();
      if (dout !== 16'(k)) begin
        errors++; $display("FAIL drain_word[%0d] got %h exp %h", k, dout, 16'(k));
      end
      checks++;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (dout !== 16'h00A0 + 16'(k)) begin errors++; $display("FAIL tail_order[%0d] got %h exp %h", k, dout, 16'h00A0 + 16'(k)); end
    end
    rd_req = 1'b0;
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL drain_cnt got %0d exp 0", dut.count_q); end
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  task automatic test_strobe_spacing();
    channels = 4'd8;
    set_din(16'h0200);
    gate_enable = 1'b1;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (2) step();
    set_din(16'h0300);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (8) step();
    checks++; if (dut.count_q !== 13'd8) begin errors++; $display("FAIL spacing_cnt got %0d exp 8", dut.count_q); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL spacing_ovf got %b exp 1", overflow); end
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (dout !== 16'h0200 + 16'(k)) begin errors++; $display("FAIL spacing_data[%0d] got %h exp %h", k, dout, 16'h0200 + 16'(k)); end
    end
    rd_req = 1'b0;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  task automatic test_flush();
    for (int f = 0; f < 24; f++) frame(4'd4, 16'h0400 + 16'(4 * f));
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    channels = 4'd5;
    set_din(16'h0600);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    repeat (3) step();
    checks++; if (dut.count_q !== 13'd100) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 100", dut.count_q); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got %b exp 1", overflow); end
    checks++; if (dout !== 16'h0400) begin errors++; $display("FAIL flush_pre_dout got %h exp 0400", dout); end
    bus_reset = 1'b1;
    rd_req = 1'b1;
    strobe = 1'b1;
    step();
    bus_reset = 1'b0;
    rd_req = 1'b0;
    strobe = 1'b0;
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", dut.count_q); end
    checks++; if (packet_rdy !== 1'b0) begin errors++; $display("FAIL flush_pkt got %b exp 0", packet_rdy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b exp 0", overflow); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL flush_dout got %h exp 0000", dout); end
    repeat (10) step();
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL flush_strobe_ignored got %0d exp 0", dut.count_q); end
  endtask

  task automatic test_async_reset();
    frame(4'd8, 16'h0500);
    frame(4'd8, 16'h0510);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    channels = 4'd8;
    set_din(16'h0700);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL areset_pre_ovf got %b exp 1", overflow); end
    checks++; if (dut.count_q !== 13'd18) begin errors++; $display("FAIL areset_pre_cnt got %0d exp 18", dut.count_q); end
    #1 reset = 1'b0;
    #1;
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", dut.count_q); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_ovf got %b exp 0", overflow); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL areset_dout got %h exp 0000", dout); end
    checks++; if (packet_rdy !== 1'b0) begin errors++; $display("FAIL areset_pkt got %b exp 0", packet_rdy); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL areset_state got %0d exp IDLE", dut.state_q); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) step();
    checks++; if (dut.count_q !== 13'd0) begin errors++; $display("FAIL areset_frame_abort got %0d exp 0", dut.count_q); end
  endtask

  initial begin
    set_din(16'h0000);
    test_reset();
    test_single_frame();
    test_gate_off();
    test_channel_bounds();
    test_back_to_back();
    test_packet();
    test_overflow();
    test_strobe_spacing();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
